// File: rtl/operand_entry_if.sv
// Bus between the calculator front-end controller and its environment
// (buttons, switches, ALU datapath, LED/display consumers).
//   btnL/btnR/btnU : raw push-buttons (load A, load B, execute)
//   sw_data        : operand switches
//   sw_sel         : operation code switches
//   alu_y          : combinational ALU result for a_out/b_out/op_sel
//   a_out/b_out    : operand registers
//   y_out          : result register
//   op_sel         : registered operation code
//   op_valid       : one-cycle execute strobe
//   busy           : controller is not idle
// master = the controller side, slave = the environment side.
interface operand_entry_if #(
  parameter int unsigned WIDTH = 8
);
  logic             btnL;
  logic             btnR;
  logic             btnU;
  logic [WIDTH-1:0] sw_data;
  logic [3:0]       sw_sel;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] y_out;
  logic [3:0]       op_sel;
  logic             op_valid;
  logic             busy;

  modport master (
    input  btnL, btnR, btnU, sw_data, sw_sel, alu_y,
    output a_out, b_out, y_out, op_sel, op_valid, busy
  );

  modport slave (
    output btnL, btnR, btnU, sw_data, sw_sel, alu_y,
    input  a_out, b_out, y_out, op_sel, op_valid, busy
  );
endinterface

// File: rtl/operand_entry.sv
// Front-end input controller for the 8-bit switch calculator.
// Synchronizes and debounces the L/R/U buttons, latches operands A and B,
// issues a registered op code with a one-cycle op_valid strobe, captures the
// ALU result into Y and performs the STO (A <= Y) and SWP (A <-> B) write-backs.
// Ports:
//   i_clk  : system clock, rising edge
//   i_btnC : synchronous active-high reset
//   bus    : operand_entry_if master modport (buttons, switches, ALU result,
//            operand/result registers, op_sel, op_valid, busy)
module operand_entry #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic              i_clk,
  input logic              i_btnC,
  operand_entry_if.master  bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] OpSto = 4'd14;
  localparam logic [3:0] OpSwp = 4'd15;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  // Button index: 0 = L (load A), 1 = R (load B), 2 = U (execute).
  logic [2:0]      w_btn_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_deb;
  logic [2:0]      r_press;
  logic [CntW-1:0] r_cnt [3];

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [3:0]       r_op_sel;
  logic             r_op_valid;
  logic             r_busy;

  assign w_btn_raw = {bus.btnU, bus.btnR, bus.btnL};

  // Synchronizer + debounce. The press pulse is registered on the same edge
  // the debounced level rises, so it is visible in the first high cycle.
  always_ff @(posedge i_clk) begin
    if (i_btnC) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_deb[i]   <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_press[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  // Control FSM with registered op_valid/busy.
  always_ff @(posedge i_clk) begin
    if (i_btnC) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_y        <= '0;
      r_op_sel   <= '0;
      r_op_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          // Priority U > L > R; lower-priority simultaneous presses are dropped.
          if (r_press[2]) begin
            r_op_sel   <= bus.sw_sel;
            r_op_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StExec;
          end else if (r_press[0]) begin
            r_a <= bus.sw_data;
          end else if (r_press[1]) begin
            r_b <= bus.sw_data;
          end
        end
        StExec: begin
          case (r_op_sel)
            OpSto:   r_a <= r_y;
            OpSwp: begin
              r_a <= r_b;
              r_b <= r_a;
            end
            default: r_y <= bus.alu_y;
          endcase
          r_busy  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.a_out    = r_a;
  assign bus.b_out    = r_b;
  assign bus.y_out    = r_y;
  assign bus.op_sel   = r_op_sel;
  assign bus.op_valid = r_op_valid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled on the falling edge.
module tb_operand_entry;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic btnC;
  int   checks = 0;
  int   errors = 0;
  int   n_pulses = 0;
  int   run = 0;
  int   max_run = 0;

  operand_entry_if #(.WIDTH(W)) bus ();

  operand_entry #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk (clk),
    .i_btnC(btnC),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU model
  always_comb begin
    case (bus.op_sel)
      4'd0:    bus.alu_y = bus.a_out + bus.b_out;
      4'd1:    bus.alu_y = bus.a_out - bus.b_out;
      4'd5:    bus.alu_y = bus.a_out & bus.b_out;
      default: bus.alu_y = bus.a_out ^ bus.b_out;
    endcase
  end

  // op_valid pulse counter and longest consecutive-high run
  always @(posedge clk) begin
    if (bus.op_valid) begin
      n_pulses <= n_pulses + 1;
      run      <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    btnC = 1'b1;
    wait_n(2);
    checks += 6;
    if (bus.a_out !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected 00", bus.a_out); end
    if (bus.b_out !== 8'h00) begin errors++; $display("FAIL reset_b: got %h expected 00", bus.b_out); end
    if (bus.y_out !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", bus.y_out); end
    if (bus.op_sel !== 4'h0) begin errors++; $display("FAIL reset_op_sel: got %h expected 0", bus.op_sel); end
    if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b expected 0", bus.op_valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    btnC = 1'b0;
    wait_n(1);
  endtask

  task automatic test_load_a;
    bus.sw_data = 8'h3C;
    bus.btnL = 1'b1;
    wait_n(6);
    checks++;
    if (bus.a_out !== 8'h00) begin errors++; $display("FAIL load_a_early: got %h expected 00", bus.a_out); end
    wait_n(1);
    checks++;
    if (bus.a_out !== 8'h3C) begin errors++; $display("FAIL load_a: got %h expected 3c", bus.a_out); end
    bus.sw_data = 8'h99;
    wait_n(3);
    checks++;
    if (bus.a_out !== 8'h3C) begin errors++; $display("FAIL load_a_hold: got %h expected 3c", bus.a_out); end
    bus.btnL = 1'b0;
    wait_n(10);
    checks++;
    if (bus.a_out !== 8'h3C) begin errors++; $display("FAIL load_a_release: got %h expected 3c", bus.a_out); end
  endtask

  task automatic test_load_b;
    bus.sw_data = 8'h05;
    bus.btnR = 1'b1;
    wait_n(7);
    checks += 2;
    if (bus.b_out !== 8'h05) begin errors++; $display("FAIL load_b: got %h expected 05", bus.b_out); end
    if (bus.a_out !== 8'h3C) begin errors++; $display("FAIL load_b_a: got %h expected 3c", bus.a_out); end
    bus.btnR = 1'b0;
    wait_n(10);
  endtask

  task automatic test_glitch;
    int base;
    base = n_pulses;
    bus.sw_sel = 4'd5;
    bus.btnU = 1'b1;
    wait_n(2);
    bus.btnU = 1'b0;
    wait_n(12);
    checks += 2;
    if (n_pulses - base !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", n_pulses - base); end
    if (bus.y_out !== 8'h00) begin errors++; $display("FAIL glitch_y: got %h expected 00", bus.y_out); end
    // bounce train, then stable high
    bus.btnU = 1'b1; wait_n(1);
    bus.btnU = 1'b0; wait_n(1);
    bus.btnU = 1'b1;
    wait_n(15);
    checks += 3;
    if (n_pulses - base !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", n_pulses - base); end
    if (bus.y_out !== 8'h04) begin errors++; $display("FAIL bounce_y: got %h expected 04", bus.y_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL bounce_busy: got %b expected 0", bus.busy); end
    bus.btnU = 1'b0;
    wait_n(10);
  endtask

  task automatic test_exec_add;
    bus.sw_sel = 4'd0;
    bus.btnU = 1'b1;
    wait_n(6);
    checks += 2;
    if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b expected 0", bus.op_valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_early_busy: got %b expected 0", bus.busy); end
    wait_n(1);
    checks += 4;
    if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", bus.op_valid); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy1: got %b expected 1", bus.busy); end
    if (bus.op_sel !== 4'd0) begin errors++; $display("FAIL add_op_sel: got %h expected 0", bus.op_sel); end
    if (bus.y_out !== 8'h04) begin errors++; $display("FAIL add_y_early: got %h expected 04", bus.y_out); end
    wait_n(1);
    checks += 3;
    if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL add_valid_off: got %b expected 0", bus.op_valid); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy2: got %b expected 1", bus.busy); end
    if (bus.y_out !== 8'h41) begin errors++; $display("FAIL add_y: got %h expected 41", bus.y_out); end
    wait_n(1);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_end: got %b expected 0", bus.busy); end
    bus.btnU = 1'b0;
    wait_n(10);
  endtask

  task automatic test_sto_swp;
    bus.sw_sel = 4'd14;
    bus.btnU = 1'b1;
    wait_n(8);
    checks += 2;
    if (bus.a_out !== 8'h41) begin errors++; $display("FAIL sto_a: got %h expected 41", bus.a_out); end
    if (bus.y_out !== 8'h41) begin errors++; $display("FAIL sto_y: got %h expected 41", bus.y_out); end
    bus.btnU = 1'b0;
    wait_n(10);
    bus.sw_sel = 4'd15;
    bus.btnU = 1'b1;
    wait_n(8);
    checks += 3;
    if (bus.a_out !== 8'h05) begin errors++; $display("FAIL swp_a: got %h expected 05", bus.a_out); end
    if (bus.b_out !== 8'h41) begin errors++; $display("FAIL swp_b: got %h expected 41", bus.b_out); end
    if (bus.y_out !== 8'h41) begin errors++; $display("FAIL swp_y: got %h expected 41", bus.y_out); end
    bus.btnU = 1'b0;
    wait_n(10);
  endtask

  task automatic test_priority;
    bus.sw_sel  = 4'd0;
    bus.sw_data = 8'hFF;
    bus.btnU = 1'b1;
    bus.btnL = 1'b1;
    wait_n(1);
    bus.btnR = 1'b1;  // its press lands in the EXEC cycle
    wait_n(6);
    checks++;
    if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL prio_valid: got %b expected 1", bus.op_valid); end
    wait_n(1);
    checks += 2;
    if (bus.y_out !== 8'h46) begin errors++; $display("FAIL prio_y: got %h expected 46", bus.y_out); end
    if (bus.a_out !== 8'h05) begin errors++; $display("FAIL prio_a: got %h expected 05", bus.a_out); end
    wait_n(5);
    checks += 2;
    if (bus.b_out !== 8'h41) begin errors++; $display("FAIL exec_r_b: got %h expected 41", bus.b_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b expected 0", bus.busy); end
    bus.btnU = 1'b0;
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    wait_n(10);
  endtask

  task automatic test_reset_mid;
    bus.sw_sel = 4'd15;
    bus.btnU = 1'b1;
    wait_n(7);
    checks++;
    if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", bus.op_valid); end
    btnC = 1'b1;
    bus.btnU = 1'b0;
    bus.btnL = 1'b1;
    bus.sw_data = 8'h77;
    wait_n(1);
    checks += 6;
    if (bus.a_out !== 8'h00) begin errors++; $display("FAIL mid_a: got %h expected 00", bus.a_out); end
    if (bus.b_out !== 8'h00) begin errors++; $display("FAIL mid_b: got %h expected 00", bus.b_out); end
    if (bus.y_out !== 8'h00) begin errors++; $display("FAIL mid_y: got %h expected 00", bus.y_out); end
    if (bus.op_sel !== 4'h0) begin errors++; $display("FAIL mid_op_sel: got %h expected 0", bus.op_sel); end
    if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL mid_op_valid: got %b expected 0", bus.op_valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    btnC = 1'b0;
    wait_n(6);
    checks++;
    if (bus.a_out !== 8'h00) begin errors++; $display("FAIL held_early: got %h expected 00", bus.a_out); end
    wait_n(1);
    checks += 2;
    if (bus.a_out !== 8'h77) begin errors++; $display("FAIL held_load: got %h expected 77", bus.a_out); end
    if (bus.b_out !== 8'h00) begin errors++; $display("FAIL held_b: got %h expected 00", bus.b_out); end
    bus.btnL = 1'b0;
    wait_n(10);
  endtask

  task automatic test_strobe_width;
    checks++;
    if (max_run !== 1) begin errors++; $display("FAIL op_valid_run: got %0d expected 1", max_run); end
  endtask

  initial begin
    btnC = 1'b1;
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnU = 1'b0;
    bus.sw_data = '0;
    bus.sw_sel = '0;
    wait_n(1);
    test_reset();
    test_load_a();
    test_load_b();
    test_glitch();
    test_exec_add();
    test_sto_swp();
    test_priority();
    test_reset_mid();
    test_strobe_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
